// File: rtl/alu_pkg.sv
// Shared ALU definitions: func codes, branch conditions,
// flag bit positions and the default flag-update mask.
`timescale 1ns/1ps
package alu_pkg;

  localparam logic [3:0] FN_NOP = 4'd0;
  localparam logic [3:0] FN_ADD = 4'd1;
  localparam logic [3:0] FN_SUB = 4'd2;
  localparam logic [3:0] FN_CMP = 4'd3;
  localparam logic [3:0] FN_AND = 4'd4;
  localparam logic [3:0] FN_OR  = 4'd5;
  localparam logic [3:0] FN_MOV = 4'd6;
  localparam logic [3:0] FN_XOR = 4'd7;
  localparam logic [3:0] FN_NOT = 4'd8;
  localparam logic [3:0] FN_SHL = 4'd9;
  localparam logic [3:0] FN_SHR = 4'd10;
  localparam logic [3:0] FN_SAR = 4'd11;
  localparam logic [3:0] FN_ROL = 4'd12;
  localparam logic [3:0] FN_ROR = 4'd13;
  localparam logic [3:0] FN_DEC = 4'd14;
  localparam logic [3:0] FN_INC = 4'd15;

  localparam logic [2:0] COND_NEVER  = 3'd0;
  localparam logic [2:0] COND_ALWAYS = 3'd1;
  localparam logic [2:0] COND_EQ     = 3'd2;
  localparam logic [2:0] COND_NE     = 3'd3;
  localparam logic [2:0] COND_LT     = 3'd4;
  localparam logic [2:0] COND_GE     = 3'd5;
  localparam logic [2:0] COND_LTU    = 3'd6;
  localparam logic [2:0] COND_GEU    = 3'd7;

  localparam int ZF = 0;
  localparam int CF = 1;
  localparam int OF = 2;
  localparam int SF = 3;

  localparam logic [15:0] FLAG_MASK_DEFAULT = 16'hFEBE;

endpackage

// File: rtl/alu_flag_unit_stack.sv
// LIFO of 4-bit flag snapshots with depth tracking and a
// sticky overflow/underflow error bit.
`timescale 1ns/1ps
module flag_stack #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear_err,
  input  logic [3:0]               din,
  output logic [3:0]               dout,
  output logic                     pop_ok,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     full,
  output logic                     empty,
  output logic                     err
);

  localparam int DW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(DEPTH);

  logic [3:0]    mem [DEPTH];
  logic          push_ok;
  logic          err_set;
  logic [DW-1:0] depth_m1;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;

  assign full     = (depth == DW'(DEPTH));
  assign empty    = (depth == '0);
  assign push_ok  = push & ~pop & ~full;
  assign pop_ok   = pop & ~push & ~empty;
  assign err_set  = (push & ~pop & full)
                  | (pop & ~push & empty);
  assign depth_m1 = depth - DW'(1);
  assign wr_idx   = depth[IW-1:0];
  assign rd_idx   = depth_m1[IW-1:0];
  assign dout     = mem[rd_idx];

  // Entry storage; contents are meaningless after reset.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_idx] <= din;
  end

  // Occupancy counter and sticky error (new error beats clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth <= '0;
      err   <= 1'b0;
    end else begin
      if (push_ok)
        depth <= depth + DW'(1);
      else if (pop_ok)
        depth <= depth_m1;
      if (err_set)
        err <= 1'b1;
      else if (clear_err)
        err <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_flag_unit.sv
// Registers ALU result and flags, evaluates branch
// conditions and saves/restores flags through a LIFO.
`timescale 1ns/1ps
module alu_flag_unit
  import alu_pkg::*;
#(
  parameter int          STACK_DEPTH = 4,
  parameter logic [15:0] FLAG_MASK   = FLAG_MASK_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_valid,
  input  logic [3:0]                    alu_func,
  input  logic [7:0]                    alu_res,
  input  logic                          alu_zf,
  input  logic                          alu_of,
  input  logic                          alu_cf,
  input  logic                          alu_sf,
  input  logic [2:0]                    cond,
  input  logic                          flag_push,
  input  logic                          flag_pop,
  input  logic                          clear_err,
  output logic [7:0]                    res_q,
  output logic                          res_valid,
  output logic [3:0]                    flags_q,
  output logic                          branch_taken,
  output logic [$clog2(STACK_DEPTH):0]  stack_depth,
  output logic                          stack_full,
  output logic                          stack_empty,
  output logic                          stack_err
);

  logic [3:0] pop_data;
  logic       pop_ok;
  logic       alu_upd;

  assign alu_upd = alu_valid & FLAG_MASK[alu_func];

  flag_stack #(
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (flag_push),
    .pop       (flag_pop),
    .clear_err (clear_err),
    .din       (flags_q),
    .dout      (pop_data),
    .pop_ok    (pop_ok),
    .depth     (stack_depth),
    .full      (stack_full),
    .empty     (stack_empty),
    .err       (stack_err)
  );

  // Result pipeline register; holds value on idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q     <= '0;
      res_valid <= 1'b0;
    end else begin
      res_valid <= alu_valid;
      if (alu_valid)
        res_q <= alu_res;
    end
  end

  // Flag register; a successful pop beats an ALU update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      flags_q <= '0;
    else if (pop_ok)
      flags_q <= pop_data;
    else if (alu_upd)
      flags_q <= {alu_sf, alu_of, alu_cf, alu_zf};
  end

  // Branch condition decode from registered flags.
  always_comb begin
    branch_taken = 1'b0;
    unique case (cond)
      COND_NEVER:  branch_taken = 1'b0;
      COND_ALWAYS: branch_taken = 1'b1;
      COND_EQ:     branch_taken = flags_q[ZF];
      COND_NE:     branch_taken = ~flags_q[ZF];
      COND_LT:     branch_taken = flags_q[SF] ^ flags_q[OF];
      COND_GE:     branch_taken = ~(flags_q[SF] ^ flags_q[OF]);
      COND_LTU:    branch_taken = flags_q[CF];
      COND_GEU:    branch_taken = ~flags_q[CF];
      default:     branch_taken = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alu_flag_unit.sv
// Scoreboard bench for alu_flag_unit: directed plan plus
// random traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_alu_flag_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       alu_valid = 1'b0;
  logic [3:0] alu_func = '0;
  logic [7:0] alu_res = '0;
  logic       alu_zf = 1'b0;
  logic       alu_of = 1'b0;
  logic       alu_cf = 1'b0;
  logic       alu_sf = 1'b0;
  logic [2:0] cond = '0;
  logic       flag_push = 1'b0;
  logic       flag_pop = 1'b0;
  logic       clear_err = 1'b0;
  logic [7:0] res_q;
  logic       res_valid;
  logic [3:0] flags_q;
  logic       branch_taken;
  logic [2:0] stack_depth;
  logic       stack_full;
  logic       stack_empty;
  logic       stack_err;

  alu_flag_unit dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .alu_func     (alu_func),
    .alu_res      (alu_res),
    .alu_zf       (alu_zf),
    .alu_of       (alu_of),
    .alu_cf       (alu_cf),
    .alu_sf       (alu_sf),
    .cond         (cond),
    .flag_push    (flag_push),
    .flag_pop     (flag_pop),
    .clear_err    (clear_err),
    .res_q        (res_q),
    .res_valid    (res_valid),
    .flags_q      (flags_q),
    .branch_taken (branch_taken),
    .stack_depth  (stack_depth),
    .stack_full   (stack_full),
    .stack_empty  (stack_empty),
    .stack_err    (stack_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] res;
    logic       rv;
    logic [3:0] fl;
    logic       tk;
    int         dep;
    logic       full;
    logic       empty;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nbad = 0;

  // reference model state
  logic [7:0] m_res;
  logic       m_rv;
  logic [3:0] m_fl;
  logic       m_err;
  logic [3:0] m_stk[$];
  localparam int MDEPTH = 4;

  function automatic logic m_taken(input logic [2:0] c,
                                   input logic [3:0] f);
    // f = {sf,of,cf,zf}
    case (c)
      3'd0: return 1'b0;
      3'd1: return 1'b1;
      3'd2: return f[0];
      3'd3: return !f[0];
      3'd4: return f[3] != f[2];
      3'd5: return f[3] == f[2];
      3'd6: return f[1];
      default: return !f[1];
    endcase
  endfunction

  function automatic logic writes_flags(input logic [3:0] fn);
    return !(fn == 4'd0 || fn == 4'd6 || fn == 4'd8);
  endfunction

  task automatic model_reset();
    m_res = '0;
    m_rv  = 1'b0;
    m_fl  = '0;
    m_err = 1'b0;
    m_stk.delete();
    q.delete();
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_func = 0; alu_res = 0;
    {alu_sf, alu_of, alu_cf, alu_zf} = 4'b0;
    cond = 0; flag_push = 0; flag_pop = 0; clear_err = 0;
  endtask

  // one clock of stimulus; model advances at the edge
  task automatic step(input logic v, input logic [3:0] fn,
                      input logic [7:0] r,
                      input logic [3:0] fl,
                      input logic [2:0] c, input logic pu,
                      input logic po, input logic ce);
    logic [3:0] old_fl;
    logic       ev;
    exp_t       e;
    @(negedge clk);
    alu_valid = v; alu_func = fn; alu_res = r;
    {alu_sf, alu_of, alu_cf, alu_zf} = fl;
    cond = c; flag_push = pu; flag_pop = po;
    clear_err = ce;
    @(posedge clk);
    old_fl = m_fl;
    ev = 1'b0;
    if (pu && !po) begin
      if (m_stk.size() == MDEPTH) ev = 1'b1;
      else m_stk.push_back(old_fl);
    end
    if (po && !pu && m_stk.size() == 0) ev = 1'b1;
    if (po && !pu && !ev)
      m_fl = m_stk.pop_back();
    else if (v && writes_flags(fn))
      m_fl = fl;
    if (ev) m_err = 1'b1;
    else if (ce) m_err = 1'b0;
    m_rv = v;
    if (v) m_res = r;
    e.res = m_res; e.rv = m_rv; e.fl = m_fl;
    e.tk = m_taken(c, m_fl);
    e.dep = m_stk.size();
    e.full = (m_stk.size() == MDEPTH);
    e.empty = (m_stk.size() == 0);
    e.err = m_err;
    q.push_back(e);
  endtask

  // monitor: compare DUT against oldest expectation
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (!rst && q.size() > 0) begin
      e = q.pop_front();
      nvec++;
      if (res_q !== e.res || res_valid !== e.rv ||
          flags_q !== e.fl || branch_taken !== e.tk ||
          int'(stack_depth) != e.dep ||
          stack_full !== e.full ||
          stack_empty !== e.empty ||
          stack_err !== e.err) begin
        nbad++;
        $display("FAIL cyc t=%0t got res=%h rv=%b fl=%b tk=%b dep=%0d f=%b e=%b err=%b want res=%h rv=%b fl=%b tk=%b dep=%0d f=%b e=%b err=%b",
                 $time, res_q, res_valid, flags_q,
                 branch_taken, stack_depth, stack_full,
                 stack_empty, stack_err, e.res, e.rv, e.fl,
                 e.tk, e.dep, e.full, e.empty, e.err);
      end
    end
  end

  task automatic chk(input string nm, input int got,
                     input int want);
    nvec++;
    if (got != want) begin
      nbad++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  logic [3:0] vals [4];

  initial begin
    idle_inputs();
    model_reset();
    rst = 1'b1;
    #12;
    chk("rst_res", int'(res_q), 0);
    chk("rst_empty", int'(stack_empty), 1);
    rst = 1'b0;

    // three pushes, then async reset mid-cycle
    step(1, 4'd1, 8'h11, 4'b0110, 3'd0, 0, 0, 0);
    step(0, 4'd0, 8'h00, 4'b0000, 3'd0, 1, 0, 0);
    step(0, 4'd0, 8'h00, 4'b0000, 3'd0, 1, 0, 0);
    step(0, 4'd0, 8'h00, 4'b0000, 3'd0, 1, 0, 0);
    #3;
    idle_inputs();
    rst = 1'b1;
    #1;
    chk("arst_flags", int'(flags_q), 0);
    chk("arst_res", int'(res_q), 0);
    chk("arst_depth", int'(stack_depth), 0);
    chk("arst_empty", int'(stack_empty), 1);
    chk("arst_err", int'(stack_err), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // compare equal, branch EQ / NE
    step(1, 4'd3, 8'h00, 4'b0001, 3'd2, 0, 0, 0);
    step(0, 4'd0, 8'h00, 4'b0000, 3'd3, 0, 0, 0);
    // masked move and not
    step(1, 4'd6, 8'h5A, 4'b1110, 3'd2, 0, 0, 0);
    step(1, 4'd8, 8'hA5, 4'b1110, 3'd2, 0, 0, 0);
    step(1, 4'd0, 8'h33, 4'b1110, 3'd2, 0, 0, 0);
    // signed/unsigned compare
    step(1, 4'd3, 8'hFF, 4'b1010, 3'd4, 0, 0, 0);
    step(0, 4'd0, 8'h00, 4'b0000, 3'd6, 0, 0, 0);
    step(0, 4'd0, 8'h00, 4'b0000, 3'd5, 0, 0, 0);
    step(0, 4'd0, 8'h00, 4'b0000, 3'd7, 0, 0, 0);
    step(0, 4'd0, 8'h00, 4'b0000, 3'd1, 0, 0, 0);
    step(0, 4'd0, 8'h00, 4'b0000, 3'd0, 0, 0, 0);

    // fill stack with four distinct flag values
    vals[0] = 4'b0011; vals[1] = 4'b0101;
    vals[2] = 4'b1001; vals[3] = 4'b1100;
    for (int i = 0; i < 4; i++) begin
      step(1, 4'd1, 8'(i), vals[i], 3'd2, 0, 0, 0);
      step(0, 4'd0, 8'h00, 4'b0000, 3'd2, 1, 0, 0);
    end
    step(0, 4'd0, 8'h00, 4'b0000, 3'd2, 1, 0, 0);
    for (int i = 0; i < 5; i++)
      step(0, 4'd0, 8'h00, 4'b0000, 3'd4, 0, 1, 0);
    step(0, 4'd0, 8'h00, 4'b0000, 3'd0, 0, 0, 1);

    // pop overrides ALU update; push+pop at depth 2
    step(1, 4'd1, 8'h10, 4'b0010, 3'd0, 0, 0, 0);
    step(0, 4'd0, 8'h00, 4'b0000, 3'd0, 1, 0, 0);
    step(1, 4'd1, 8'h20, 4'b1000, 3'd0, 0, 0, 0);
    step(0, 4'd0, 8'h00, 4'b0000, 3'd0, 1, 0, 0);
    step(1, 4'd1, 8'h77, 4'b0001, 3'd3, 0, 1, 0);
    step(0, 4'd0, 8'h00, 4'b0000, 3'd0, 1, 0, 0);
    step(1, 4'd2, 8'h99, 4'b0100, 3'd4, 1, 1, 0);
    // error set and clear in the same cycle
    step(0, 4'd0, 8'h00, 4'b0000, 3'd0, 0, 1, 0);
    step(0, 4'd0, 8'h00, 4'b0000, 3'd0, 0, 1, 0);
    step(0, 4'd0, 8'h00, 4'b0000, 3'd0, 0, 1, 1);
    step(0, 4'd0, 8'h00, 4'b0000, 3'd0, 0, 0, 1);

    // random traffic
    for (int i = 0; i < 400; i++)
      step(($urandom % 4) != 0, 4'($urandom),
           8'($urandom), 4'($urandom), 3'($urandom),
           ($urandom % 3) == 0, ($urandom % 3) == 0,
           ($urandom % 8) == 0);

    @(negedge clk);
    idle_inputs();
    @(posedge clk);
    #4;
    chk("drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule

// File: doc/alu_flag_unit.md
Name: alu_flag_unit

Overview:
- Sits directly downstream of the 8-bit ALU in the single-cycle datapath.
- Registers the ALU result and its zf/of/cf/sf outputs into an architectural flag register, but only for functions that produce flags.
- Evaluates branch conditions from the registered flags.
- Provides a small LIFO flag stack so that interrupt and call sequences can save and restore flags.

Parameters:
- STACK_DEPTH, 4: number of flag-stack entries, legal range 2..8.
- FLAG_MASK, 16'hFEBE: bit f set means ALU func f updates the flags. Functions 0 (no-op), 6 (move/li) and 8 (not) leave the flags unchanged.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU output valid this cycle.
- alu_func  in  4  func code that produced the result.
- alu_res  in  8  ALU result.
- alu_zf, alu_of, alu_cf, alu_sf  in  1 each  ALU flags.
- cond  in  3  branch condition select.
- flag_push  in  1  push flags_q onto the stack.
- flag_pop  in  1  pop the stack top into flags_q.
- clear_err  in  1  clear stack_err.
- res_q  out  8  registered result.
- res_valid  out  1  registered alu_valid.
- flags_q  out  4  {sf,of,cf,zf}.
- branch_taken  out  1  condition outcome.
- stack_depth  out  $clog2(STACK_DEPTH)+1  occupied entries.
- stack_full, stack_empty  out  1 each.
- stack_err  out  1  sticky overflow/underflow flag.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - res_q=0, res_valid=0, flags_q=0, stack_depth=0, stack_err=0, stack_empty=1, stack_full=0.
  - Stack contents are don't-care after reset.
- Result path, one-cycle latency:
  - If alu_valid, then res_q<=alu_res.
  - res_valid<=alu_valid every cycle.
  - res_q holds its value when alu_valid=0.
- Flag update: when alu_valid && FLAG_MASK[alu_func], flags_q<={alu_sf,alu_of,alu_cf,alu_zf} at the next edge.
- Condition codes, combinational from flags_q (registered, so no bypass):
  - 0 NEVER: 0.
  - 1 ALWAYS: 1.
  - 2 EQ: zf.
  - 3 NE: ~zf.
  - 4 LT: sf^of.
  - 5 GE: ~(sf^of).
  - 6 LTU: cf.
  - 7 GEU: ~cf.
  - A compare must be issued at least one cycle before the branch that uses it.
- Stack operations:
  - Push only (not full): entry[depth]<=flags_q (value before any same-cycle ALU update); depth+1.
  - Pop only (not empty): flags_q<=entry[depth-1]; depth-1. The pop overrides any same-cycle ALU flag update. res_q still updates.
  - Push and pop in the same cycle: both are ignored, no error raised. ALU update rule applies.
  - Push when full: ignored; stack_err<=1; depth unchanged.
  - Pop when empty: ignored; stack_err<=1; ALU update rule applies.
- Flag combinational decodes: stack_full = (depth==STACK_DEPTH); stack_empty = (depth==0).
- Error flag:
  - stack_err is sticky until clear_err.
  - If clear_err and a new error occur in the same cycle, the error wins (stack_err=1).
- No other state. No state machine beyond the depth counter.

Decomposition:
- Shared package alu_pkg:
  - ALU func code constants (NOP..INC, 0..15).
  - Condition code constants (COND_NEVER..COND_GEU).
  - Flag bit indices (ZF=0, CF=1, OF=2, SF=3).
  - Default FLAG_MASK constant.
- Sub-module flag_stack:
  - Parameterised LIFO of 4-bit entries with push/pop/depth/full/empty/err.
  - alu_flag_unit instantiates it and owns the pop-override mux.

Test Plan:
- Reset: assert rst asynchronously mid-cycle after three pushes → immediately flags_q=0, res_q=0, stack_depth=0, stack_empty=1, stack_err=0.
- Compare equal: alu_valid, func=3, res=8'h00, zf=1, cf=0, sf=0, of=0 → next cycle res_q=8'h00, flags_q=4'b0001. cond=2 → taken=1; cond=3 → taken=0.
- Masked function: after the above, alu_valid, func=6, res=8'h5A, zf=0 → res_q=8'h5A, flags_q stays 4'b0001, EQ still taken.
- Signed/unsigned compare: func=3, res=8'hFF, cf=1, sf=1, of=0, zf=0 → flags_q=4'b1010. LT=1, LTU=1, GE=0, GEU=0.
- Stack boundaries: load 4 distinct flag values and push 4 times → stack_full=1, depth=4. 5th push → stack_err=1, depth=4. 4 pops return flags in reverse order. 5th pop → flags unchanged, stack_err stays 1. clear_err → 0.
- Simultaneous events: pop with alu_valid func=1 in the same cycle → flags_q=popped value, res_q=alu_res. Push+pop in the same cycle at depth 2 → depth stays 2, no error.
